// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// The fetch stage is the master: it drives req/addr and consumes ready/rdata.
interface instruction_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/instruction_fetch_stage.sv
// Fetch stage feeding the decode controller.
// Owns the PC, issues one outstanding imem request at a time, and registers the
// returned word into the IF/ID register. A one-entry buffer catches a word that
// arrives while decode is stalled. S_DROP swallows a response that was already
// in flight when a redirect changed the PC.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4,
  parameter int          CNT_W    = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_stall,
  input  logic                     i_redirect,
  input  logic [31:0]              i_redirect_pc,
  instruction_fetch_stage_if.master imem,
  output logic [31:0]              o_instruction,
  output logic [31:0]              o_pc_plus4,
  output logic                     o_instr_valid,
  output logic [CNT_W-1:0]         o_bubble_count
);

  localparam logic [31:0] LP_STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_BUF  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_pc;
  logic [31:0]        w_pc_next;
  logic [31:0]        r_buf_instr;
  logic [31:0]        w_buf_instr_next;
  logic [31:0]        r_buf_pc4;
  logic [31:0]        w_buf_pc4_next;
  logic [31:0]        r_instr;
  logic [31:0]        w_instr_next;
  logic [31:0]        r_pc4;
  logic [31:0]        w_pc4_next;
  logic               r_valid;
  logic               w_valid_next;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_next;
  logic               w_bubble;
  logic [31:0]        w_pc_inc;

  assign w_pc_inc = r_pc + LP_STEP;

  // Request is held low during reset so a responding memory never sees a live fetch.
  assign imem.req  = i_rst_n && (r_state != S_BUF);
  assign imem.addr = r_pc;

  assign o_instruction  = r_instr;
  assign o_pc_plus4     = r_pc4;
  assign o_instr_valid  = r_valid;
  assign o_bubble_count = r_count;

  // State register plus PC, buffer, IF/ID and bubble counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_buf_instr <= 32'h0;
      r_buf_pc4   <= 32'h0;
      r_instr     <= 32'h0;
      r_pc4       <= 32'h0;
      r_valid     <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_buf_instr <= w_buf_instr_next;
      r_buf_pc4   <= w_buf_pc4_next;
      r_instr     <= w_instr_next;
      r_pc4       <= w_pc4_next;
      r_valid     <= w_valid_next;
      r_count     <= w_count_next;
    end
  end

  // Next-state and datapath decisions; redirect overrides every state's normal action.
  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_buf_instr_next = r_buf_instr;
    w_buf_pc4_next   = r_buf_pc4;
    w_instr_next     = r_instr;
    w_pc4_next       = r_pc4;
    w_valid_next     = r_valid;
    w_bubble         = 1'b0;

    if (i_redirect) begin
      // Flush even under stall; an outstanding request must have its reply dropped.
      w_pc_next        = i_redirect_pc;
      w_buf_instr_next = 32'h0;
      w_buf_pc4_next   = 32'h0;
      w_bubble         = 1'b1;
      if ((r_state == S_DROP) || ((r_state == S_REQ) && !imem.ready))
        w_state_next = S_DROP;
      else
        w_state_next = S_REQ;
    end else begin
      case (r_state)
        S_REQ: begin
          if (imem.ready) begin
            w_pc_next = w_pc_inc;
            if (!i_stall) begin
              w_instr_next = imem.rdata;
              w_pc4_next   = w_pc_inc;
              w_valid_next = 1'b1;
            end else begin
              w_buf_instr_next = imem.rdata;
              w_buf_pc4_next   = w_pc_inc;
              w_state_next     = S_BUF;
            end
          end else if (!i_stall) begin
            w_bubble = 1'b1;
          end
        end
        S_BUF: begin
          if (!i_stall) begin
            w_instr_next     = r_buf_instr;
            w_pc4_next       = r_buf_pc4;
            w_valid_next     = 1'b1;
            w_buf_instr_next = 32'h0;
            w_buf_pc4_next   = 32'h0;
            w_state_next     = S_REQ;
          end
        end
        S_DROP: begin
          if (imem.ready)
            w_state_next = S_REQ;
          if (!i_stall)
            w_bubble = 1'b1;
        end
        default: begin
          w_state_next = S_REQ;
        end
      endcase
    end

    // A bubble keeps PCPlus4 and clears the word and its valid flag.
    if (w_bubble) begin
      w_instr_next = 32'h0;
      w_valid_next = 1'b0;
    end

    w_count_next = r_count;
    if (w_bubble && (r_count != {CNT_W{1'b1}}))
      w_count_next = r_count + 1'b1;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Fetch stage directly upstream of the decode controller.
- Owns the program counter and issues requests to instruction memory using a req/ready handshake.
- Registers the fetched word into the IF/ID pipeline register; the controller decodes that word's opcode [31:26].
- Handles decode stall, branch/jump redirect, and dropping responses that are no longer wanted.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Rst  input  1  asynchronous, active-low reset.
- Stall  input  1  decode cannot accept; IF/ID register holds.
- Redirect  input  1  taken branch/jump, one-cycle pulse.
- RedirectPC  input  32  target PC, sampled when Redirect=1.
- IMemReq  output  1  fetch request valid.
- IMemAddr  output  32  fetch address, equals PC.
- IMemReady  input  1  memory returns IMemRdata this cycle.
- IMemRdata  input  32  fetched instruction word.
- Instruction  output  32  IF/ID instruction, to controller.
- PCPlus4  output  32  IF/ID address of fetched word + PC_STEP.
- InstrValid  output  1  IF/ID holds a real instruction.
- BubbleCount  output  CNT_W  saturating count of bubbles inserted.

Behaviour:
- Reset (Rst=0, async), all outputs and state:
  - PC=RESET_PC, state=S_REQ.
  - Instruction=32'h0, PCPlus4=0, InstrValid=0, BubbleCount=0, buffer empty.
  - IMemReq=0 while Rst=0.
- Combinational outputs:
  - IMemReq=1 in S_REQ and S_DROP, 0 in S_BUF.
  - IMemAddr=PC at all times.
- Handshake rules:
  - While IMemReq=1 and IMemReady=0, PC and IMemAddr are stable.
  - One request is outstanding at most.
- State S_REQ:
  - IMemReady=1 and Stall=0: IF/ID<={IMemRdata, PC+PC_STEP, 1}, PC<=PC+PC_STEP, stay. Sustained throughput is one instruction per cycle.
  - IMemReady=1 and Stall=1: capture IMemRdata and PC+PC_STEP into the buffer, PC<=PC+PC_STEP, go S_BUF. IF/ID holds.
  - IMemReady=0 and Stall=0: IF/ID<=bubble {32'h0, PCPlus4 unchanged, 0}, BubbleCount++.
- State S_BUF:
  - No request is issued.
  - Stall=0: IF/ID<=buffer with valid=1, buffer empties, go S_REQ.
  - Stall=1: hold.
- State S_DROP:
  - Wait for IMemReady; discard the returned data, go S_REQ.
  - IF/ID loads a bubble whenever Stall=0.
- Redirect (priority over everything except reset):
  - PC<=RedirectPC, buffer discarded, IF/ID<=bubble with InstrValid=0. The bubble is loaded even when Stall=1, because a redirect flushes the stage.
  - If in S_REQ with IMemReady=0 (request outstanding): go S_DROP.
  - Otherwise go S_REQ. Any response arriving in the redirect cycle is discarded.
  - Redirect in S_DROP: update PC only, remain in S_DROP.
- Stall=1 without Redirect: Instruction, PCPlus4 and InstrValid are unchanged.
- BubbleCount:
  - Increments once per cycle in which IF/ID loads a bubble (Stall=0 and no valid instruction, or a redirect flush).
  - Saturates at 2^CNT_W-1; no wrap.
- PC arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0). No alignment check; RedirectPC is used as given.
- Reset asserted mid-operation: immediate return to the reset state. Any in-flight response is ignored, since IMemReq=0.

Test Plan:
- Reset release, IMemReady=1 every cycle, Rdata=32'h2008_0005, 32'h0000_0000, ... -> IMemAddr 0,4,8,... Instruction=32'h2008_0005, PCPlus4=4, InstrValid=1 one cycle after the first handshake. BubbleCount=0.
- Stall=1 for 3 cycles while IMemReady=1 at PC=8 -> IF/ID frozen, state S_BUF, IMemReq=0, PC=12. On release the buffered word loads with PCPlus4=12, then the fetch at 12 resumes.
- IMemReady=0 for 2 cycles, Stall=0 -> two bubbles (Instruction=0, InstrValid=0), BubbleCount=2, IMemAddr stable throughout.
- Redirect=1, RedirectPC=32'h40, request at 16 outstanding -> S_DROP. The next IMemReady word is discarded, then a fetch at 32'h40 is issued and its word loads with PCPlus4=32'h44.
- Redirect and Stall in the same cycle as IMemReady=1 -> response dropped, IF/ID flushed to bubble, next IMemAddr=RedirectPC.
- Rst pulled low mid-S_BUF -> outputs reset asynchronously. After release IMemAddr=RESET_PC and the buffer is empty.
